// File: rtl/idu_pipe.sv
// idu_pipe: pipelined RV32/RV64 instruction decode unit between IFU and EXU.
//  Fetched words arrive over a valid/ready handshake and sit in a DEPTH-entry
//  circular queue. The oldest word (or the incoming word when the queue is
//  empty) is decoded and registered into an output bundle held until EXU
//  consumes it.
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  flush_i             drop queue contents and output bundle (redirect)
//  in_valid_i/in_ready_o, inst_i, pc_i      IFU side
//  out_valid_o/out_ready_i, pc_o            EXU side handshake and PC
//  opinfo_o/alu_o/branch_o/load_o/store_o/sys_o  one-hot decode classes
//  rd_o/rs1_o/rs2_o    register fields, imm_o sign-extended immediate
//  wen_reg_o           instruction writes rd, illegal_o undecodable word
module idu_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int PC_W  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PC_W-1:0] pc_o,
    output logic [11:0]     opinfo_o,
    output logic [9:0]      alu_o,
    output logic [5:0]      branch_o,
    output logic [6:0]      load_o,
    output logic [3:0]      store_o,
    output logic [1:0]      sys_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [XLEN-1:0] imm_o,
    output logic            wen_reg_o,
    output logic            illegal_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit RV32 = (XLEN == 32);

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    // ---------------- queue ----------------
    logic [31:0]     q_inst [DEPTH];
    logic [PC_W-1:0] q_pc   [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic empty, in_xfer, load_out, src_valid, pop, push, bypass;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready_o = (count < CW'(DEPTH));
    assign empty      = (count == '0);
    assign in_xfer    = in_valid_i & in_ready_o;
    assign load_out   = ~out_valid_o | out_ready_i;
    assign src_valid  = ~empty | in_xfer;
    assign pop        = load_out & ~empty;
    // An empty queue with a free output slot hands the word straight to decode.
    assign bypass     = load_out & empty & in_xfer;
    assign push       = in_xfer & ~bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            q_inst[wr_ptr] <= inst_i;
            q_pc[wr_ptr]   <= pc_i;
        end
    end

    // ---------------- decode ----------------
    logic [31:0]     s;
    logic [PC_W-1:0] s_pc;
    assign s    = empty ? inst_i : q_inst[rd_ptr];
    assign s_pc = empty ? pc_i   : q_pc[rd_ptr];

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    assign opc = s[6:0];
    assign f3  = s[14:12];
    assign f7  = s[31:25];

    logic [11:0] d_op;
    logic [9:0]  d_alu;
    logic [5:0]  d_br;
    logic [6:0]  d_ld;
    logic [3:0]  d_st;
    logic [1:0]  d_sys;
    logic        d_ill, d_wen;
    imm_sel_e    isel;
    logic [31:0] imm32;
    logic [XLEN-1:0] d_imm;

    always_comb begin
        d_op  = '0;
        d_alu = '0;
        d_br  = '0;
        d_ld  = '0;
        d_st  = '0;
        d_sys = '0;
        d_ill = 1'b0;
        isel  = IMM_NONE;
        case (opc)
            7'b0110011: begin
                d_op[0] = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: d_alu[0] = 1'b1;
                        3'd1: d_alu[5] = 1'b1;
                        3'd2: d_alu[8] = 1'b1;
                        3'd3: d_alu[9] = 1'b1;
                        3'd4: d_alu[2] = 1'b1;
                        3'd5: d_alu[6] = 1'b1;
                        3'd6: d_alu[3] = 1'b1;
                        default: d_alu[4] = 1'b1;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) d_alu[1] = 1'b1;
                else if (f7 == 7'h20 && f3 == 3'd5)     d_alu[7] = 1'b1;
                else d_ill = 1'b1;
            end
            7'b0010011: begin
                d_op[1] = 1'b1;
                isel    = IMM_I;
                case (f3)
                    3'd0: d_alu[0] = 1'b1;
                    3'd2: d_alu[8] = 1'b1;
                    3'd3: d_alu[9] = 1'b1;
                    3'd4: d_alu[2] = 1'b1;
                    3'd6: d_alu[3] = 1'b1;
                    3'd7: d_alu[4] = 1'b1;
                    3'd1: if (s[31:26] == 6'd0) d_alu[5] = 1'b1; else d_ill = 1'b1;
                    default: begin
                        if (s[31:26] == 6'd0)          d_alu[6] = 1'b1;
                        else if (s[31:26] == 6'b010000) d_alu[7] = 1'b1;
                        else d_ill = 1'b1;
                    end
                endcase
                // shamt[5] only exists in RV64
                if (RV32 && (f3 == 3'd1 || f3 == 3'd5) && s[25]) d_ill = 1'b1;
            end
            7'b0111011: begin
                d_op[2] = 1'b1;
                if (f7 == 7'h00 && f3 == 3'd0)      d_alu[0] = 1'b1;
                else if (f7 == 7'h20 && f3 == 3'd0) d_alu[1] = 1'b1;
                else if (f7 == 7'h00 && f3 == 3'd1) d_alu[5] = 1'b1;
                else if (f7 == 7'h00 && f3 == 3'd5) d_alu[6] = 1'b1;
                else if (f7 == 7'h20 && f3 == 3'd5) d_alu[7] = 1'b1;
                else d_ill = 1'b1;
                if (RV32) d_ill = 1'b1;
            end
            7'b0011011: begin
                d_op[3] = 1'b1;
                isel    = IMM_I;
                if (f3 == 3'd0)                     d_alu[0] = 1'b1;
                else if (f7 == 7'h00 && f3 == 3'd1) d_alu[5] = 1'b1;
                else if (f7 == 7'h00 && f3 == 3'd5) d_alu[6] = 1'b1;
                else if (f7 == 7'h20 && f3 == 3'd5) d_alu[7] = 1'b1;
                else d_ill = 1'b1;
                if (RV32) d_ill = 1'b1;
            end
            7'b1100011: begin
                d_op[4] = 1'b1;
                isel    = IMM_B;
                case (f3)
                    3'd0: d_br[0] = 1'b1;
                    3'd1: d_br[1] = 1'b1;
                    3'd4: d_br[2] = 1'b1;
                    3'd5: d_br[3] = 1'b1;
                    3'd6: d_br[4] = 1'b1;
                    3'd7: d_br[5] = 1'b1;
                    default: d_ill = 1'b1;
                endcase
            end
            7'b1101111: begin
                d_op[5] = 1'b1;
                isel    = IMM_J;
            end
            7'b1100111: begin
                d_op[6] = 1'b1;
                isel    = IMM_I;
                if (f3 != 3'd0) d_ill = 1'b1;
            end
            7'b0000011: begin
                d_op[7] = 1'b1;
                isel    = IMM_I;
                if (f3 == 3'd7) d_ill = 1'b1;
                else d_ld[f3] = 1'b1;
                if (RV32 && (f3 == 3'd3 || f3 == 3'd6)) d_ill = 1'b1;
            end
            7'b0100011: begin
                d_op[8] = 1'b1;
                isel    = IMM_S;
                if (f3[2]) d_ill = 1'b1;
                else d_st[f3[1:0]] = 1'b1;
                if (RV32 && f3 == 3'd3) d_ill = 1'b1;
            end
            7'b0110111: begin
                d_op[9] = 1'b1;
                isel    = IMM_U;
            end
            7'b0010111: begin
                d_op[10] = 1'b1;
                isel     = IMM_U;
            end
            7'b1110011: begin
                d_op[11] = 1'b1;
                if (s == 32'h0000_0073)      d_sys[0] = 1'b1;
                else if (s == 32'h0010_0073) d_sys[1] = 1'b1;
                else d_ill = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase

        // Illegal words carry no class bits so EXU cannot act on them.
        if (d_ill) begin
            d_op  = '0;
            d_alu = '0;
            d_br  = '0;
            d_ld  = '0;
            d_st  = '0;
            d_sys = '0;
            isel  = IMM_NONE;
        end
    end

    always_comb begin
        case (isel)
            IMM_I:   imm32 = {{20{s[31]}}, s[31:20]};
            IMM_S:   imm32 = {{20{s[31]}}, s[31:25], s[11:7]};
            IMM_B:   imm32 = {{19{s[31]}}, s[31], s[7], s[30:25], s[11:8], 1'b0};
            IMM_U:   imm32 = {s[31:12], 12'b0};
            IMM_J:   imm32 = {{11{s[31]}}, s[31], s[19:12], s[20], s[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign d_imm = XLEN'($signed(imm32));
    assign d_wen = ~d_ill & ~(d_op[4] | d_op[8] | d_op[11]);

    // ---------------- output register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            pc_o        <= '0;
            opinfo_o    <= '0;
            alu_o       <= '0;
            branch_o    <= '0;
            load_o      <= '0;
            store_o     <= '0;
            sys_o       <= '0;
            rd_o        <= '0;
            rs1_o       <= '0;
            rs2_o       <= '0;
            imm_o       <= '0;
            wen_reg_o   <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (load_out) begin
            out_valid_o <= src_valid;
            if (src_valid) begin
                pc_o      <= s_pc;
                opinfo_o  <= d_op;
                alu_o     <= d_alu;
                branch_o  <= d_br;
                load_o    <= d_ld;
                store_o   <= d_st;
                sys_o     <= d_sys;
                rd_o      <= s[11:7];
                rs1_o     <= s[19:15];
                rs2_o     <= s[24:20];
                imm_o     <= d_imm;
                wen_reg_o <= d_wen;
                illegal_o <= d_ill;
            end
        end
    end
endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: an RV64 instance and an RV32 instance share
// stimulus; each task drives one scenario and checks results inline.
module tb_idu_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst = '0;
    logic [63:0] pc = '0;

    logic        in_ready, out_valid, wen, ill;
    logic [63:0] pc_o, imm;
    logic [11:0] opinfo;
    logic [9:0]  alu;
    logic [5:0]  br;
    logic [6:0]  ld;
    logic [3:0]  st;
    logic [1:0]  sys;
    logic [4:0]  rd, rs1, rs2;

    logic        in_ready32, out_valid32, wen32, ill32;
    logic [31:0] pc_o32, imm32;
    logic [11:0] opinfo32;
    logic [9:0]  alu32;
    logic [5:0]  br32;
    logic [6:0]  ld32;
    logic [3:0]  st32;
    logic [1:0]  sys32;
    logic [4:0]  rd32, rs132, rs232;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    idu_pipe #(.XLEN(64), .DEPTH(2), .PC_W(64)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_i(inst), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_o),
        .opinfo_o(opinfo), .alu_o(alu), .branch_o(br), .load_o(ld), .store_o(st), .sys_o(sys),
        .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .imm_o(imm), .wen_reg_o(wen), .illegal_o(ill));

    idu_pipe #(.XLEN(32), .DEPTH(2), .PC_W(32)) d32 (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready32),
        .inst_i(inst), .pc_i(pc[31:0]), .out_valid_o(out_valid32), .out_ready_i(out_ready),
        .pc_o(pc_o32), .opinfo_o(opinfo32), .alu_o(alu32), .branch_o(br32), .load_o(ld32),
        .store_o(st32), .sys_o(sys32), .rd_o(rd32), .rs1_o(rs132), .rs2_o(rs232), .imm_o(imm32),
        .wen_reg_o(wen32), .illegal_o(ill32));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single edge with EXU ready, then sample.
    task automatic send_one(input logic [31:0] w, input logic [63:0] p);
        in_valid = 1'b1; inst = w; pc = p; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else passes++;
        checks++; if ({opinfo, imm, wen} !== '0) $display("FAIL reset_outputs got %h/%h/%b want 0", opinfo, imm, wen); else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_addi();
        send_one(32'h0050_0093, 64'h100);
        checks++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %b want 1", out_valid); else passes++;
        checks++; if (opinfo !== 12'h002 || alu !== 10'h001) $display("FAIL addi_class got %h/%h want 002/001", opinfo, alu); else passes++;
        checks++; if (rd !== 5'd1 || imm !== 64'd5) $display("FAIL addi_fields got rd %0d imm %h want 1/5", rd, imm); else passes++;
        checks++; if (wen !== 1'b1 || ill !== 1'b0) $display("FAIL addi_flags got wen %b ill %b want 1/0", wen, ill); else passes++;
        checks++; if (pc_o !== 64'h100) $display("FAIL addi_pc got %h want 100", pc_o); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL addi_drain got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_decode_mix();
        send_one(32'hFE00_0EE3, 64'h200); // beq x0,x0,-4
        checks++; if (opinfo !== 12'h010 || br !== 6'h01) $display("FAIL beq_class got %h/%h want 010/01", opinfo, br); else passes++;
        checks++; if (imm !== 64'hFFFF_FFFF_FFFF_FFFC || wen !== 1'b0) $display("FAIL beq_imm got %h wen %b want ..FC/0", imm, wen); else passes++;
        send_one(32'h1234_52B7, 64'h204); // lui x5,0x12345
        checks++; if (opinfo !== 12'h200 || imm !== 64'h1234_5000 || rd !== 5'd5) $display("FAIL lui got %h/%h/%0d want 200/12345000/5", opinfo, imm, rd); else passes++;
        send_one(32'h0081_3183, 64'h208); // ld x3,8(x2)
        checks++; if (opinfo !== 12'h080 || ld !== 7'h08 || imm !== 64'd8 || rs1 !== 5'd2) $display("FAIL ld got %h/%h/%h/%0d want 080/08/8/2", opinfo, ld, imm, rs1); else passes++;
        send_one(32'h4031_00B3, 64'h20C); // sub x1,x2,x3
        checks++; if (opinfo !== 12'h001 || alu !== 10'h002 || rs2 !== 5'd3 || imm !== 64'd0) $display("FAIL sub got %h/%h/%0d/%h want 001/002/3/0", opinfo, alu, rs2, imm); else passes++;
        send_one(32'h0000_0073, 64'h210); // ecall
        checks++; if (opinfo !== 12'h800 || sys !== 2'b01 || wen !== 1'b0) $display("FAIL ecall got %h/%b/%b want 800/01/0", opinfo, sys, wen); else passes++;
        send_one(32'h0000_0000, 64'h214); // unknown opcode
        checks++; if (out_valid !== 1'b1 || ill !== 1'b1 || opinfo !== 12'h0 || wen !== 1'b0) $display("FAIL illegal got v%b i%b %h w%b want 1/1/000/0", out_valid, ill, opinfo, wen); else passes++;
        tick();
    endtask

    task automatic test_xlen();
        send_one(32'h0011_3023, 64'h300); // sd x1,0(x2)
        checks++; if (st !== 4'h8 || ill !== 1'b0 || opinfo !== 12'h100 || wen !== 1'b0) $display("FAIL sd64 got %h/%b/%h/%b want 8/0/100/0", st, ill, opinfo, wen); else passes++;
        checks++; if (out_valid32 !== 1'b1 || ill32 !== 1'b1 || st32 !== 4'h0 || wen32 !== 1'b0) $display("FAIL sd32 got v%b i%b %h w%b want 1/1/0/0", out_valid32, ill32, st32, wen32); else passes++;
        send_one(32'h0200_9093, 64'h304); // slli x1,x1,32
        checks++; if (ill !== 1'b0 || alu !== 10'h020) $display("FAIL slli64 got i%b %h want 0/020", ill, alu); else passes++;
        checks++; if (ill32 !== 1'b1 || alu32 !== 10'h000) $display("FAIL slli32 got i%b %h want 1/000", ill32, alu32); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1;
        inst = 32'h0010_0093; pc = 64'h400; tick();   // x1 -> output register
        checks++; if (out_valid !== 1'b1 || rd !== 5'd1 || in_ready !== 1'b1) $display("FAIL bp_first got v%b rd%0d r%b want 1/1/1", out_valid, rd, in_ready); else passes++;
        inst = 32'h0020_0113; pc = 64'h404; tick();   // x2 queued
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %b want 1", in_ready); else passes++;
        inst = 32'h0030_0193; pc = 64'h408; tick();   // x3 queued, full
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_full got %b want 0", in_ready); else passes++;
        inst = 32'h0040_0213; pc = 64'h40C; tick();   // x4 refused
        checks++; if (rd !== 5'd1 || pc_o !== 64'h400 || in_ready !== 1'b0) $display("FAIL bp_hold got rd%0d pc%h r%b want 1/400/0", rd, pc_o, in_ready); else passes++;
        out_ready = 1'b1; tick();                     // pop while full: x4 still refused
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || rd !== 5'd2 || in_ready !== 1'b1) $display("FAIL bp_order2 got v%b rd%0d r%b want 1/2/1", out_valid, rd, in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || rd !== 5'd3 || pc_o !== 64'h408) $display("FAIL bp_order3 got v%b rd%0d pc%h want 1/3/408", out_valid, rd, pc_o); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        inst = 32'h0010_0093; tick();
        inst = 32'h0020_0113; tick();
        inst = 32'h0030_0193; tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL fl_setup got r%b v%b want 0/1", in_ready, out_valid); else passes++;
        flush = 1'b1; inst = 32'h0040_0213; tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL fl_clear got v%b r%b want 0/1", out_valid, in_ready); else passes++;
        out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL fl_nothing1 got %b want 0", out_valid); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL fl_nothing2 got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        inst = 32'h0010_0093; tick();
        inst = 32'h0020_0113; tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL ar_setup got %b want 1", out_valid); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || rd !== 5'd0) $display("FAIL ar_immediate got v%b r%b rd%0d want 0/1/0", out_valid, in_ready, rd); else passes++;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL ar_lost got %b want 0", out_valid); else passes++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_decode_mix();
        test_xlen();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
